imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Sequences one shared single-port word memory between the multi-cycle CPU's instruction-fetch path (IF) and its load/store path (D).
- Sits between the fetch/MEM stages and the memory array.
- Performs arbitration, wait-state counting and misaligned-access rejection.
- Returns read data with a one-cycle acknowledge pulse per completed access.

Parameters:
- LATENCY, 2, cycles mem_en/mem_addr are held before mem_rdata is sampled (legal range 1..15).
- ADDR_W, 32, byte-address width for both requesters and the memory side.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request; held high with if_addr stable until if_ack
- if_addr  input  ADDR_W  fetch byte address
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid this cycle
- if_rdata  output  32  fetched instruction word
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  input  1  1 = store word, 0 = load word
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  32  store data
- d_ack  output  1  one-cycle pulse: data access complete (or rejected)
- d_rdata  output  32  load data, valid with d_ack when d_we=0
- d_err  output  1  pulses with d_ack when d_addr[1:0]!=0; no memory access performed
- mem_en  output  1  memory access strobe, held for the whole access
- mem_we  output  1  memory write enable, held for the whole access
- mem_addr  output  ADDR_W  byte address to memory
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  memory read data, valid in the LATENCY-th cycle of mem_en
- busy  output  1  high while not in IDLE

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, counter=0, owner=IF, last_grant=D, all acks/d_err/mem_en/mem_we=0, rdata/mem_addr/mem_wdata=0.
- States:
  - IDLE, ACCESS, RESP.
  - IDLE: if a request is pending, select owner; register the owner's address, we and wdata into mem_*; load counter=LATENCY-1; go to ACCESS. Otherwise stay.
  - ACCESS: mem_en=1, mem_we=owner's we. Decrement the counter each cycle. At counter==0, capture mem_rdata into the owner's rdata register, drop mem_en/mem_we, go to RESP.
  - RESP: pulse the owner's ack for exactly one cycle, update last_grant=owner, go to IDLE.
- Access latency: from the req-high sampling edge to the ack-high cycle is LATENCY+2 cycles. At least one IDLE cycle separates back-to-back accesses.
- Misaligned data (d_addr[1:0]!=0, either d_we value) granted in IDLE: skip ACCESS, go directly to RESP with d_ack=1, d_err=1, d_rdata unchanged, mem_en never asserted.
- IF address alignment is not checked; the low 2 bits pass through on mem_addr.
- if_rdata and d_rdata hold their last captured value between accesses. A store does not modify d_rdata.
- Request dropped mid-access (protocol violation): the access completes and the ack still pulses.
- Reset asserted in ACCESS/RESP: abort immediately, no ack issued, memory write strobe removed. Requesters must reissue after reset.
- Counter width is 4 bits. LATENCY=1 gives exactly one ACCESS cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous if_req and d_req in IDLE, grant the requester that is not last_grant (alternation).
- Undefined: fixed priority, D always wins over IF. last_grant is still maintained but not used.
- A single requester is always granted regardless of the macro.

Test Plan:
- Fetch only, LATENCY=2: if_req=1, if_addr=0x00003004, mem returns 0x2408000A -> mem_en high 2 cycles with mem_addr=0x00003004, if_ack one pulse 4 cycles after req, if_rdata=0x2408000A.
- Store then load: d_we=1, d_addr=0x00000010, d_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles, d_ack pulse, d_err=0. Then load of the same address returns 0xDEADBEEF on d_rdata.
- Misaligned: d_req, d_addr=0x00000013 -> d_ack and d_err high together 2 cycles after req, mem_en stays 0.
- Contention: if_req and d_req both high from the same cycle -> without macro D acked first, then IF. With ARB_ROUND_ROBIN_EN and last_grant=D, IF acked first.
- Reset mid-store: assert rst during the 2nd ACCESS cycle -> mem_en/mem_we drop within the same cycle, no d_ack, busy=0. After rst release, a reissued request completes normally.
- LATENCY=1 build: single fetch -> mem_en high exactly 1 cycle, if_ack 3 cycles after req.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port word memory between instruction fetch (IF) and load/store (D).
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention (default: D wins).
module imem_dmem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_D    = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       grant_d;
  logic       d_misaligned;

  assign d_misaligned = (d_addr[1:0] != 2'b00);
  assign busy         = (state != S_IDLE);

  always_comb begin
    grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // On contention hand the memory to whoever did not have it last.
    grant_d = d_req && (!if_req || (last_grant == OWN_IF));
`else
    grant_d = d_req;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      owner      <= OWN_IF;
      last_grant <= OWN_D;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            owner <= OWN_D;
            if (d_misaligned) begin
              // Rejected without touching memory; the ack carries the error.
              d_ack <= 1'b1;
              d_err <= 1'b1;
              state <= S_RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              cnt       <= CNT_INIT;
              state     <= S_ACCESS;
            end
          end else if (if_req) begin
            owner    <= OWN_IF;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            cnt      <= CNT_INIT;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            if (owner == OWN_D) begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if_ack     <= 1'b0;
          d_ack      <= 1'b0;
          d_err      <= 1'b0;
          last_grant <= owner;
          state      <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter against a small behavioural word memory.
module tb_imem_dmem_arbiter;
  localparam int LATENCY = 2;
  localparam int ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_ack;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              d_req, d_we, d_ack, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              busy;

  int n_chk = 0;
  int n_pass = 0;

  imem_dmem_arbiter #(.LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem_en ? mem[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // Running totals of strobe cycles; tasks take before/after snapshots.
  int          en_cycles = 0;
  int          we_cycles = 0;
  logic [31:0] seen_addr = 32'h0;
  always @(negedge clk) begin
    if (mem_en) begin
      en_cycles <= en_cycles + 1;
      seen_addr <= mem_addr;
    end
    if (mem_we) we_cycles <= we_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One access from a single requester; lat = clock edges from req driven to ack seen.
  task automatic run(input logic is_d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                     output logic err, output int en_n, output int we_n);
    int en0, we0;
    bit got;
    @(posedge clk); #1;
    en0 = en_cycles; we0 = we_cycles;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else      begin if_req = 1; if_addr = addr; end
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = is_d ? d_ack : if_ack;
    end
    if (!got) chk("ack_timeout", 32'(lat), 32'(LATENCY + 1));
    rd  = is_d ? d_rdata : if_rdata;
    err = d_err;
    d_req = 0; if_req = 0;
    @(posedge clk); #1;
    en_n = en_cycles - en0;
    we_n = we_cycles - we0;
  endtask

  int          lat, en_n, we_n;
  logic [31:0] rd;
  logic        err;
  string       order;

  initial begin
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h2408000A;
    #12;
    chk("rst_busy",   32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_acks",   32'({if_ack, d_ack, d_err, mem_we}), 0);
    chk("rst_rdata",  if_rdata | d_rdata, 0);
    chk("rst_maddr",  mem_addr, 0);
    @(negedge clk); rst = 0;

    // Fetch: two ACCESS cycles, ack in the 4th cycle counting the request cycle.
    run(0, 0, 32'h00003004, 0, lat, rd, err, en_n, we_n);
    chk("fetch_lat",   32'(lat), 32'(LATENCY + 1));
    chk("fetch_en",    32'(en_n), 32'(LATENCY));
    chk("fetch_addr",  seen_addr, 32'h00003004);
    chk("fetch_rdata", rd, 32'h2408000A);

    // IF alignment is not checked; low bits pass through.
    run(0, 0, 32'h00003006, 0, lat, rd, err, en_n, we_n);
    chk("fetch_unal_addr",  seen_addr, 32'h00003006);
    chk("fetch_unal_rdata", rd, 32'h2408000A);

    run(1, 1, 32'h00000010, 32'hDEADBEEF, lat, rd, err, en_n, we_n);
    chk("store_lat", 32'(lat), 32'(LATENCY + 1));
    chk("store_we",  32'(we_n), 32'(LATENCY));
    chk("store_err", 32'(err), 0);
    chk("store_rd_hold", rd, 32'h0);

    run(1, 0, 32'h00000010, 0, lat, rd, err, en_n, we_n);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_err",   32'(err), 0);

    run(1, 0, 32'h00000013, 0, lat, rd, err, en_n, we_n);
    chk("mis_lat",   32'(lat), 1);
    chk("mis_err",   32'(err), 1);
    chk("mis_en",    32'(en_n), 0);
    chk("mis_rdata", rd, 32'hDEADBEEF);
    chk("if_rdata_hold", if_rdata, 32'h2408000A);

    // Reset during the second ACCESS cycle of a store.
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h00000020; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_pre_en", 32'(mem_en), 1);
    rst = 1; #1;
    chk("midrst_en",   32'(mem_en), 0);
    chk("midrst_we",   32'(mem_we), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ack",  32'(d_ack), 0);
    d_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_noack", 32'(d_ack), 0);
    rst = 0;

    run(1, 1, 32'h00000020, 32'h12345678, lat, rd, err, en_n, we_n);
    chk("reissue_lat", 32'(lat), 32'(LATENCY + 1));
    run(1, 0, 32'h00000020, 0, lat, rd, err, en_n, we_n);
    chk("reissue_rdata", rd, 32'h12345678);

    // Contention with last_grant = D.
    @(posedge clk); #1;
    order = "";
    if_req = 1; if_addr = 32'h00003004;
    d_req = 1; d_we = 0; d_addr = 32'h00000010;
    for (int c = 0; c < 40 && (if_req || d_req); c++) begin
      @(posedge clk); #1;
      if (d_ack)  begin order = {order, "D"}; d_req = 0; end
      if (if_ack) begin order = {order, "I"}; if_req = 0; end
    end
    chk("cont_done", 32'({if_req, d_req}), 0);
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont_order", 32'(order == "ID"), 1);
`else
    chk("cont_order", 32'(order == "DI"), 1);
`endif
    chk("cont_if_rdata", if_rdata, 32'h2408000A);
    chk("cont_d_rdata",  d_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
